pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Hazard and stall sequencer for the IF/ID pipeline register and the program counter.
- Generates the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble controls from four inputs: instruction-cache hit, load-use hazard operands, taken-branch resolution and an external halt request.
- Holds a miss-wait state machine with a programmable minimum refill latency.
- Keeps saturating performance counters for misses and stall cycles.

Parameters:
- MISS_LATENCY, 4, minimum cycles spent in MISS before a hit may resume fetch (must be ≥1).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- hit  in  1  instruction cache hit for the current fetch address.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- branch_taken  in  1  the branch in EX resolved taken this cycle.
- halt_req  in  1  external request to freeze fetch.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  load NOP into IF/ID; overrides if_id_write.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- state  out  2  current state: 0 RUN, 1 MISS, 2 HALT.
- miss_count  out  CNT_W  number of miss events, saturating.
- stall_count  out  CNT_W  cycles with pc_write=0, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state becomes RUN; miss_timer, miss_count and stall_count become 0.
  - While rst_n is low, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
  - Reset mid-MISS or mid-HALT aborts immediately.
- load_use (combinational) = ex_mem_read & (ex_rt≠0) & (ex_rt==id_rs | ex_rt==id_rt).
- Outputs are combinational from state and inputs. Priority order: branch_taken > miss/MISS > halt > load_use.
- RUN:
  - branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1; stay in RUN. A miss in the same cycle is ignored because the PC is redirected.
  - Else if hit=0:
    - pc_write=0.
    - If load_use: if_id_write=0, if_id_flush=0, id_ex_bubble=1.
    - Otherwise: if_id_flush=1, id_ex_bubble=0.
    - Next state MISS; miss_timer←MISS_LATENCY-1; miss_count++.
  - Else if halt_req: pc_write=0, if_id_write=0, id_ex_bubble=1; next state HALT.
  - Else if load_use: pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle; stay in RUN.
  - Else: pc_write=1, if_id_write=1, flush=0, bubble=0.
- MISS:
  - branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1; next state RUN; miss_timer←0. The outstanding miss is abandoned.
  - Else:
    - pc_write=0; IF/ID control follows the same load_use rule as the RUN miss cycle.
    - miss_timer decrements while >0.
    - When miss_timer==0 and hit=1: next state RUN. The RUN cycle that follows fetches normally.
    - When miss_timer==0 and hit=0: stay in MISS, timer held at 0.
  - halt_req is ignored in MISS; it is sampled again once in RUN.
- HALT:
  - pc_write=0, if_id_write=0, if_id_flush=0.
  - id_ex_bubble=1, so downstream drains.
  - Next state RUN in the cycle after halt_req is sampled 0.
  - branch_taken in HALT: pc_write=1, if_id_flush=1, id_ex_bubble=1, stay in HALT.
- Counters:
  - stall_count increments on every clk edge with rst_n=1 and pc_write=0.
  - Both counters saturate at 2^CNT_W−1; there is no wrap-around.
- Invariant: if_id_flush=1 implies if_id_write is don't-care. The bench must check that if_id_flush and load_use hold are never both active.

Test Plan:
1. Reset held 3 cycles, then released with hit=1 and no hazards → during reset pc_write=0 and if_id_flush=1; afterwards state=0, pc_write=1, if_id_write=1, both counters 0.
2. RUN, hit=0 for 6 cycles, then hit=1, MISS_LATENCY=4 → state=1 for 6 cycles; pc_write=0 and if_id_flush=1 throughout; return to RUN on the 7th edge; miss_count=1, stall_count=6.
3. RUN, ex_mem_read=1, ex_rt=5, id_rs=5, hit=1 for one cycle → exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_rt=0 → no stall.
4. RUN, hit=0 together with load_use → if_id_write=0, if_id_flush=0, id_ex_bubble=1; state becomes MISS.
5. MISS with miss_timer=2, branch_taken=1 → pc_write=1, if_id_flush=1, id_ex_bubble=1; next state RUN; a later hit=0 starts a fresh miss with miss_count=2.
6. RUN, halt_req=1 for 3 cycles → state=2, pc_write=0, id_ex_bubble=1; RUN resumes one cycle after halt_req drops. Pre-load stall_count near 2^16−1 → it stops at 65535.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall sequencer for the PC and IF/ID register: cache-miss wait FSM,
// load-use interlock, branch flush, external halt, and saturating perf counters.
module pipeline_stall_controller #(
  parameter int MISS_LATENCY = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int TW = (MISS_LATENCY < 2) ? 1 : $clog2(MISS_LATENCY);
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(MISS_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             miss_event;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Control outputs and next state; reset overrides everything at the end.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    timer_d      = timer_q;
    miss_event   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          if_id_write  = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (!hit) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            if_id_flush = 1'b1;
          end
          state_d    = MISS;
          timer_d    = TIMER_LOAD;
          miss_event = 1'b1;
        end else if (halt_req) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = HALT;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end

      MISS: begin
        if (branch_taken) begin
          // Redirect abandons the outstanding refill.
          if_id_write  = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = RUN;
          timer_d      = '0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            if_id_flush = 1'b1;
          end
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (hit) begin
            state_d = RUN;
          end
        end
      end

      HALT: begin
        if (branch_taken) begin
          if_id_write  = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (!halt_req) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
        timer_d      = '0;
      end
    endcase

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    miss_cnt_d  = miss_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (miss_event && (miss_cnt_q != CNT_MAX)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
    if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      timer_q     <= '0;
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      miss_cnt_q  <= miss_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state       = state_q;
  assign miss_count  = miss_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a priority-rule model is compared
// against the DUT every cycle, plus hand-computed checkpoints along the way.
module tb_pipeline_stall_controller;

  localparam int    MISS_LATENCY = 4;
  localparam int    CNT_W        = 16;
  localparam longint CNT_MAX     = (longint'(1) << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             hit;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             branch_taken;
  logic             halt_req;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] stall_count;

  int checkCount;
  int errorCount;

  int     mState;
  int     mTimer;
  longint mMiss;
  longint mStall;

  pipeline_stall_controller #(
    .MISS_LATENCY(MISS_LATENCY),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hit         (hit),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .branch_taken(branch_taken),
    .halt_req    (halt_req),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .state       (state),
    .miss_count  (miss_count),
    .stall_count (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isLoadUse(input bit memRd, input logic [4:0] rt, input logic [4:0] rs,
                                   input logic [4:0] rt2);
    return memRd && (rt != 5'd0) && ((rt == rs) || (rt == rt2));
  endfunction

  // Priority: reset, redirect, halt freeze, fetch miss, halt request, load-use, normal.
  function automatic void computeModel(
      input int st, input int tmr, input bit rstN, input bit hitV, input bit lu,
      input bit br, input bit hl,
      output bit ePc, output bit eWr, output bit eFl, output bit eBub,
      output int nSt, output int nTmr, output bit missEv);
    ePc = 1'b1; eWr = 1'b1; eFl = 1'b0; eBub = 1'b0;
    nSt = st; nTmr = tmr; missEv = 1'b0;
    if (!rstN) begin
      ePc = 1'b0; eWr = 1'b0; eFl = 1'b1; eBub = 1'b1;
      nSt = 0; nTmr = 0;
    end else if (br) begin
      eWr = 1'b0; eFl = 1'b1; eBub = 1'b1;
      if (st == 1) begin
        nSt = 0; nTmr = 0;
      end
    end else if (st == 2) begin
      ePc = 1'b0; eWr = 1'b0; eBub = 1'b1;
      if (!hl) nSt = 0;
    end else if (st == 1 || !hitV) begin
      ePc = 1'b0; eWr = 1'b0;
      if (lu) eBub = 1'b1;
      else    eFl  = 1'b1;
      if (st == 0) begin
        nSt = 1; nTmr = MISS_LATENCY - 1; missEv = 1'b1;
      end else if (tmr > 0) begin
        nTmr = tmr - 1;
      end else if (hitV) begin
        nSt = 0;
      end
    end else if (hl) begin
      ePc = 1'b0; eWr = 1'b0; eBub = 1'b1; nSt = 2;
    end else if (lu) begin
      ePc = 1'b0; eWr = 1'b0; eBub = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    bit ePc, eWr, eFl, eBub, missEv;
    int nSt, nTmr;
    computeModel(mState, mTimer, rst_n, hit, isLoadUse(ex_mem_read, ex_rt, id_rs, id_rt),
                 branch_taken, halt_req, ePc, eWr, eFl, eBub, nSt, nTmr, missEv);
    if (!rst_n) begin
      mState = 0; mTimer = 0; mMiss = 0; mStall = 0;
    end else begin
      if (!ePc && mStall < CNT_MAX) mStall++;
      if (missEv && mMiss < CNT_MAX) mMiss++;
      mState = nSt;
      mTimer = nTmr;
    end
  end

  always @(negedge clk) begin
    bit ePc, eWr, eFl, eBub, missEv, lu;
    int nSt, nTmr;
    lu = isLoadUse(ex_mem_read, ex_rt, id_rs, id_rt);
    computeModel(mState, mTimer, rst_n, hit, lu, branch_taken, halt_req,
                 ePc, eWr, eFl, eBub, nSt, nTmr, missEv);
    checkOutput("pc_write", pc_write, ePc);
    checkOutput("if_id_flush", if_id_flush, eFl);
    checkOutput("id_ex_bubble", id_ex_bubble, eBub);
    if (!eFl) checkOutput("if_id_write", if_id_write, eWr);
    checkOutput("state", state, mState);
    checkOutput("miss_count", miss_count, mMiss);
    checkOutput("stall_count", stall_count, mStall);
    if (rst_n && !branch_taken && lu) checkOutput("flushVsLoadUse", if_id_flush, 0);
  end

  task automatic applyStimulus(input bit rstN, input bit hitV, input bit memRd,
                               input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                               input bit br, input bit hl);
    rst_n = rstN; hit = hitV; ex_mem_read = memRd;
    ex_rt = rt; id_rs = rs; id_rt = rt2;
    branch_taken = br; halt_req = hl;
    @(negedge clk);
    #1;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextEdge();
  endtask

  initial begin
    checkCount = 0; errorCount = 0;
    mState = 0; mTimer = 0; mMiss = 0; mStall = 0;
    rst_n = 1'b0; hit = 1'b1; ex_mem_read = 1'b0;
    ex_rt = '0; id_rs = '0; id_rt = '0;
    branch_taken = 1'b0; halt_req = 1'b0;

    // Reset held three cycles, then released into normal fetch.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("rstPcWrite", pc_write, 0);
      checkOutput("rstFlush", if_id_flush, 1);
      nextEdge();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("postRstState", state, 0);
    checkOutput("postRstPc", pc_write, 1);
    checkOutput("postRstWr", if_id_write, 1);
    checkOutput("postRstMiss", miss_count, 0);
    checkOutput("postRstStall", stall_count, 0);
    nextEdge();

    // Six miss cycles then a hit; refill minimum is long past by then.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("missPc", pc_write, 0);
      checkOutput("missFlush", if_id_flush, 1);
      nextEdge();
      checkOutput("missState", state, 1);
    end
    checkOutput("missStall6", stall_count, 6);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("missHitPc", pc_write, 0);
    nextEdge();
    checkOutput("missExitState", state, 0);
    checkOutput("missCount1", miss_count, 1);
    checkOutput("missStall7", stall_count, 7);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("resumePc", pc_write, 1);
    nextEdge();

    // Load-use stall, then a load to r0 which must not stall.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    checkOutput("luPc", pc_write, 0);
    checkOutput("luWr", if_id_write, 0);
    checkOutput("luBub", id_ex_bubble, 1);
    nextEdge();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    checkOutput("luOnceOnly", pc_write, 1);
    nextEdge();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("luR0Pc", pc_write, 1);
    checkOutput("luR0Bub", id_ex_bubble, 0);
    nextEdge();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    checkOutput("luRtPc", pc_write, 0);
    nextEdge();

    // Miss together with load-use, then a redirect two cycles into the refill.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
    checkOutput("missLuWr", if_id_write, 0);
    checkOutput("missLuFlush", if_id_flush, 0);
    checkOutput("missLuBub", id_ex_bubble, 1);
    nextEdge();
    checkOutput("missLuState", state, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("brMissPc", pc_write, 1);
    checkOutput("brMissFlush", if_id_flush, 1);
    checkOutput("brMissBub", id_ex_bubble, 1);
    nextEdge();
    checkOutput("brMissState", state, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextEdge();
    checkOutput("freshMissCount", miss_count, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    nextEdge();
    checkOutput("brIgnoresMiss", state, 0);
    checkOutput("brIgnoresMissCnt", miss_count, 2);

    // Halt for three cycles, release, then a branch arriving during halt.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      checkOutput("haltPc", pc_write, 0);
      checkOutput("haltBub", id_ex_bubble, 1);
      nextEdge();
      checkOutput("haltState", state, 2);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("haltDropPc", pc_write, 0);
    nextEdge();
    checkOutput("haltExitState", state, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    checkOutput("haltBrPc", pc_write, 1);
    checkOutput("haltBrFlush", if_id_flush, 1);
    nextEdge();
    checkOutput("haltBrState", state, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextEdge();
    checkOutput("haltBrExit", state, 0);

    // Long halt drives stall_count into saturation.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (65540) nextEdge();
    checkOutput("stallSat", stall_count, 65535);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextEdge();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("stallNoWrap", stall_count, 65535);
    checkOutput("satExitState", state, 0);
    nextEdge();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
